// File: rtl/iob_asym_fifo_ctrl_w_narrow_r_wide.sv
// Controller for an asymmetric FIFO: narrow words are pushed one at a time into an
// external dual-port RAM and read back RATIO at a time as one wide word.
module iob_asym_fifo_ctrl_w_narrow_r_wide #(
    parameter int W_DATA_W = 8,
    parameter int R_DATA_W = 32,
    parameter int W_ADDR_W = 8,
    parameter int R_ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [W_DATA_W-1:0] push_data,
    input  logic                pop,
    output logic [R_DATA_W-1:0] pop_data,
    output logic                pop_valid,
    output logic                full,
    output logic                empty,
    output logic [W_ADDR_W:0]   level,
    output logic                overflow,
    output logic                underflow,
    output logic                ram_w_en,
    output logic [W_ADDR_W-1:0] ram_w_addr,
    output logic [W_DATA_W-1:0] ram_w_data,
    output logic                ram_r_en,
    output logic [R_ADDR_W-1:0] ram_r_addr,
    input  logic [R_DATA_W-1:0] ram_r_data
);

    localparam int RATIO = R_DATA_W / W_DATA_W;
    localparam logic [W_ADDR_W:0] DEPTH_L = {1'b1, {W_ADDR_W{1'b0}}};
    localparam logic [W_ADDR_W:0] RATIO_L = (W_ADDR_W + 1)'(RATIO);

    logic [W_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [R_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W_ADDR_W:0]   level_q, level_d;
    logic                pop_valid_q;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                push_acc, pop_acc;

    // Flags depend only on the registered level, so a same-cycle pop never frees room.
    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q < RATIO_L);
    assign level = level_q;

    assign push_acc = rst_n && push && !full;
    assign pop_acc  = rst_n && pop && !empty;

    assign ram_w_en   = push_acc;
    assign ram_w_addr = wr_ptr_q;
    assign ram_w_data = push_data;
    assign ram_r_en   = pop_acc;
    assign ram_r_addr = rd_ptr_q;

    assign pop_data  = ram_r_data;
    assign pop_valid = pop_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_acc, pop_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - RATIO_L;
            2'b11:   level_d = level_q + 1'b1 - RATIO_L;
            default: level_d = level_q;
        endcase
        if (push && full) begin
            overflow_d = 1'b1;
        end
        // A partial group (fewer than RATIO words) also counts as an underflow.
        if (pop && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            pop_valid_q <= pop_acc;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_iob_asym_fifo_ctrl_w_narrow_r_wide.sv
// Directed bench for the asymmetric FIFO controller with a behavioural RAM attached.
module tb_iob_asym_fifo_ctrl_w_narrow_r_wide;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic [7:0]  push_data;
    logic        pop;
    logic [31:0] pop_data;
    logic        pop_valid;
    logic        full;
    logic        empty;
    logic [8:0]  level;
    logic        overflow;
    logic        underflow;
    logic        ram_w_en;
    logic [7:0]  ram_w_addr;
    logic [7:0]  ram_w_data;
    logic        ram_r_en;
    logic [5:0]  ram_r_addr;
    logic [31:0] ram_r_data;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  mem [256];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    iob_asym_fifo_ctrl_w_narrow_r_wide dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .underflow  (underflow),
        .ram_w_en   (ram_w_en),
        .ram_w_addr (ram_w_addr),
        .ram_w_data (ram_w_data),
        .ram_r_en   (ram_r_en),
        .ram_r_addr (ram_r_addr),
        .ram_r_data (ram_r_data)
    );

    // Narrow-write / wide-read RAM, one cycle read latency, first-pushed word in the LSBs.
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= {mem[{ram_r_addr, 2'd3}], mem[{ram_r_addr, 2'd2}],
                                     mem[{ram_r_addr, 2'd1}], mem[{ram_r_addr, 2'd0}]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; returns 1 ns after it so outputs are stable.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; push = 1'b0; pop = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic push_w(input logic [7:0] d);
        push = 1'b1; push_data = d; pop = 1'b0;
        cyc();
        push = 1'b0;
    endtask

    initial begin
        int lvl;
        int pushed;
        int pops_seen;
        int cycles;
        logic [31:0] grp;

        rst_n = 1'b0; push = 1'b1; push_data = 8'hAA; pop = 1'b1;
        #1;
        chk("rst_w_en", 32'(ram_w_en), 32'd0);
        chk("rst_r_en", 32'(ram_r_en), 32'd0);
        cyc(); cyc();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        push = 1'b0; pop = 1'b0; rst_n = 1'b1;

        // Basic group of four words
        push = 1'b1; push_data = 8'h11; #1;
        chk("w_en_first", 32'(ram_w_en), 32'd1);
        chk("w_addr_first", 32'(ram_w_addr), 32'd0);
        chk("w_data_first", 32'(ram_w_data), 32'h11);
        cyc();
        push_w(8'h22); push_w(8'h33); push_w(8'h44);
        chk("lvl4", 32'(level), 32'd4);
        chk("not_empty4", 32'(empty), 32'd0);
        pop = 1'b1; #1;
        chk("r_en_first", 32'(ram_r_en), 32'd1);
        chk("r_addr_first", 32'(ram_r_addr), 32'd0);
        cyc();
        pop = 1'b0;
        chk("pv_first", 32'(pop_valid), 32'd1);
        chk("pdata_first", pop_data, 32'h44332211);
        chk("lvl_after_pop", 32'(level), 32'd0);
        chk("empty_after_pop", 32'(empty), 32'd1);
        cyc();
        chk("pv_drop", 32'(pop_valid), 32'd0);

        // Partial group: pop refused, underflow sticky
        push_w(8'h55); push_w(8'h66); push_w(8'h77);
        pop = 1'b1; #1;
        chk("partial_empty", 32'(empty), 32'd1);
        chk("partial_r_en", 32'(ram_r_en), 32'd0);
        cyc();
        pop = 1'b0;
        chk("underflow_set", 32'(underflow), 32'd1);
        chk("partial_level", 32'(level), 32'd3);
        chk("partial_pv", 32'(pop_valid), 32'd0);
        push_w(8'h88);
        chk("group_empty", 32'(empty), 32'd0);
        pop = 1'b1; #1;
        chk("r_addr_second", 32'(ram_r_addr), 32'd1);
        cyc();
        pop = 1'b0;
        chk("pdata_second", pop_data, 32'h88776655);
        chk("underflow_sticky", 32'(underflow), 32'd1);

        // Fill to full, then overflow
        do_reset();
        chk("uf_cleared", 32'(underflow), 32'd0);
        for (int i = 0; i < 256; i++) push_w(8'(i));
        chk("full_set", 32'(full), 32'd1);
        chk("full_level", 32'(level), 32'd256);
        push = 1'b1; push_data = 8'hEE; #1;
        chk("ovf_w_en", 32'(ram_w_en), 32'd0);
        cyc();
        push = 1'b0;
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd256);
        // Pop in the same cycle does not make room for the push
        push = 1'b1; push_data = 8'hEF; pop = 1'b1; #1;
        chk("full_pp_w_en", 32'(ram_w_en), 32'd0);
        chk("full_pp_r_en", 32'(ram_r_en), 32'd1);
        cyc();
        push = 1'b0; pop = 1'b0;
        chk("full_pp_level", 32'(level), 32'd252);
        chk("full_pp_data", pop_data, 32'h03020100);

        // Simultaneous push and pop at level 8
        do_reset();
        for (int i = 0; i < 8; i++) push_w(8'hA0 + 8'(i));
        push = 1'b1; push_data = 8'hB0; pop = 1'b1; #1;
        chk("pp_w_en", 32'(ram_w_en), 32'd1);
        chk("pp_r_en", 32'(ram_r_en), 32'd1);
        chk("pp_w_addr", 32'(ram_w_addr), 32'd8);
        cyc();
        push = 1'b0; pop = 1'b0;
        chk("pp_level", 32'(level), 32'd5);
        chk("pp_pdata", pop_data, 32'hA3A2A1A0);

        // Stream 1024 words with interleaved pops; pointers wrap four times
        do_reset();
        lvl = 0; pushed = 0; pops_seen = 0; cycles = 0;
        while ((pushed < 1024 || lvl >= 4 || pop_valid) && cycles < 4000) begin
            push = (pushed < 1024);
            push_data = 8'(pushed * 7 + 3);
            pop = (lvl >= 4) && (cycles % 2 == 1);
            if (push) begin
                grp = {push_data, grp[31:8]};
                if (pushed % 4 == 3) exp_q.push_back(grp);
            end
            lvl = lvl + (push ? 1 : 0) - (pop ? 4 : 0);
            pushed = pushed + (push ? 1 : 0);
            cyc();
            cycles++;
            if (pop_valid) begin
                pops_seen++;
                if (exp_q.size() == 0) chk("stream_extra_pop", 32'd1, 32'd0);
                else chk("stream_data", pop_data, exp_q.pop_front());
            end
        end
        push = 1'b0; pop = 1'b0;
        chk("stream_timeout", 32'(cycles < 4000), 32'd1);
        chk("stream_pops", 32'(pops_seen), 32'd256);
        chk("stream_level", 32'(level), 32'd0);
        chk("stream_flags", {30'd0, overflow, underflow}, 32'd0);

        // Reset straight after an accepted pop
        do_reset();
        pop = 1'b1; cyc(); pop = 1'b0;
        chk("pre_uf", 32'(underflow), 32'd1);
        for (int i = 0; i < 4; i++) push_w(8'hC0 + 8'(i));
        pop = 1'b1; cyc();
        chk("pre_rst_pv", 32'(pop_valid), 32'd1);
        rst_n = 1'b0; push = 1'b1; pop = 1'b1; #1;
        chk("rst_mid_w_en", 32'(ram_w_en), 32'd0);
        cyc();
        push = 1'b0; pop = 1'b0; rst_n = 1'b1;
        chk("rst_mid_pv", 32'(pop_valid), 32'd0);
        chk("rst_mid_level", 32'(level), 32'd0);
        chk("rst_mid_flags", {30'd0, overflow, underflow}, 32'd0);
        chk("rst_mid_empty", 32'(empty), 32'd1);
        cyc();
        chk("post_rst_pv", 32'(pop_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/iob_asym_fifo_ctrl_w_narrow_r_wide.md
IOB_ASYM_FIFO_CTRL_W_NARROW_R_WIDE -- requirements
Module: iob_asym_fifo_ctrl_w_narrow_r_wide

Interface
REQ-001 Parameter W_DATA_W, default 8: narrow push word width.
REQ-002 Parameter R_DATA_W, default 32: wide pop word width; integer multiple of W_DATA_W, RATIO = R_DATA_W/W_DATA_W, power of two.
REQ-003 Parameter W_ADDR_W, default 8: narrow address width; DEPTH = 2**W_ADDR_W narrow words.
REQ-004 Parameter R_ADDR_W, default 6: wide address width; SHALL equal W_ADDR_W - log2(RATIO).
REQ-005 clk  input  1: single clock; all logic on its rising edge.
REQ-006 rst_n  input  1: reset, synchronous, active-low.
REQ-007 push  input  1: push request for one narrow word.
REQ-008 push_data  input  W_DATA_W: word to push.
REQ-009 pop  input  1: pop request for one wide word.
REQ-010 pop_data  output  R_DATA_W: popped wide word, driven from ram_r_data.
REQ-011 pop_valid  output  1: pop_data valid this cycle.
REQ-012 full  output  1: level == DEPTH.
REQ-013 empty  output  1: level < RATIO.
REQ-014 level  output  W_ADDR_W+1: stored narrow-word count.
REQ-015 overflow, underflow  output  1 each: sticky error flags.
REQ-016 ram_w_en, ram_w_addr (W_ADDR_W), ram_w_data (W_DATA_W)  output: RAM write port; ram_r_en, ram_r_addr (R_ADDR_W)  output: RAM read port; ram_r_data  input  R_DATA_W: RAM read data, registered one cycle after ram_r_en; RAM wclk and rclk tie to clk.

Function
REQ-017 Push accepted iff push && !full; full/empty use pre-edge level; a same-cycle pop never frees room for a push.
REQ-018 Pop accepted iff pop && !empty.
REQ-019 Accepted push: ram_w_en=1, ram_w_addr=wr_ptr, ram_w_data=push_data combinationally in that cycle; wr_ptr increments mod DEPTH at the edge.
REQ-020 Accepted pop: ram_r_en=1, ram_r_addr=rd_ptr combinationally; rd_ptr increments mod 2**R_ADDR_W at the edge.
REQ-021 ram_w_en and ram_r_en SHALL be 0 in every cycle without an accepted push/pop, and while rst_n=0.
REQ-022 pop_valid SHALL be a register set to 1 in the cycle after an accepted pop, else 0; read latency exactly 1 cycle; back-to-back pops give pop_valid continuously high.
REQ-023 pop_data = ram_r_data unmodified; narrow word pushed first of each group of RATIO occupies bits [W_DATA_W-1:0], last occupies MSBs.
REQ-024 Level update per edge: +1 push only, -RATIO pop only, +1-RATIO both, unchanged neither.
REQ-025 Push attempted while full: no write, state unchanged, overflow set to 1 until reset.
REQ-026 Pop attempted while empty (including partial group, 1..RATIO-1 words): no read, underflow set to 1 until reset.
REQ-027 Pointers wrap silently; wrap SHALL not affect flags or level.
REQ-028 full, empty, level combinational from registered level only.

Reset
REQ-029 On clk edge with rst_n=0: wr_ptr=0, rd_ptr=0, level=0, pop_valid=0, overflow=0, underflow=0; hence full=0, empty=1; RAM contents not cleared.
REQ-030 Reset mid-operation overrides same-cycle push/pop; a pop accepted the cycle before reset SHALL not produce pop_valid after reset.

Verification (defaults: RATIO=4, DEPTH=256)
REQ-031 Reset, push 0x11,0x22,0x33,0x44, pop -> ram_r_addr=0, next cycle pop_valid=1, pop_data=0x44332211, level=0, empty=1.
REQ-032 Push 3 words, pop -> empty=1, no ram_r_en, underflow=1, level=3; 4th push -> empty=0.
REQ-033 Push 256 words -> full=1, level=256; 257th push -> ram_w_en=0, overflow=1, level=256.
REQ-034 level=8, push and pop same cycle -> level=5, ram_w_en=1 and ram_r_en=1 same cycle.
REQ-035 Stream 1024 words with interleaved pops (pointer wrap 4x) -> all wide words in order, no flags set.
REQ-036 Pop accepted, rst_n=0 next cycle -> pop_valid=0, level=0, flags 0, empty=1.
